// File: rtl/color_scan_ctrl.sv
// Colour sensor scan sequencer: cycles the filter through red/green/blue/clear and counts sensor edges per filter.
// Define COLOR_SCAN_CONT_EN to rescan continuously after each frame instead of returning to IDLE.
module color_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sensor_out,
  output logic [1:0]       cs,
  output logic [CNT_W-1:0] red_raw,
  output logic [CNT_W-1:0] green_raw,
  output logic [CNT_W-1:0] blue_raw,
  output logic [CNT_W-1:0] clear_raw,
  output logic             frame_valid,
  output logic             busy
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  localparam logic [1:0] CS_RED   = 2'b00;
  localparam logic [1:0] CS_GREEN = 2'b01;
  localparam logic [1:0] CS_BLUE  = 2'b11;
  localparam logic [1:0] CS_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cs_q, cs_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] sh_red_q, sh_red_d;
  logic [CNT_W-1:0] sh_green_q, sh_green_d;
  logic [CNT_W-1:0] sh_blue_q, sh_blue_d;
  logic [CNT_W-1:0] red_raw_q, red_raw_d;
  logic [CNT_W-1:0] green_raw_q, green_raw_d;
  logic [CNT_W-1:0] blue_raw_q, blue_raw_d;
  logic [CNT_W-1:0] clear_raw_q, clear_raw_d;
  logic             frame_valid_q, frame_valid_d;
  logic             busy_q, busy_d;
  logic             edge_det;

  // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the delayed copy for edge detection
  assign sync_d   = {sync_q[1:0], sensor_out};
  assign edge_det = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      cnt_q         <= '0;
      cs_q          <= CS_RED;
      sync_q        <= '0;
      sh_red_q      <= '0;
      sh_green_q    <= '0;
      sh_blue_q     <= '0;
      red_raw_q     <= '0;
      green_raw_q   <= '0;
      blue_raw_q    <= '0;
      clear_raw_q   <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      cs_q          <= cs_d;
      sync_q        <= sync_d;
      sh_red_q      <= sh_red_d;
      sh_green_q    <= sh_green_d;
      sh_blue_q     <= sh_blue_d;
      red_raw_q     <= red_raw_d;
      green_raw_q   <= green_raw_d;
      blue_raw_q    <= blue_raw_d;
      clear_raw_q   <= clear_raw_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cnt_d         = cnt_q;
    cs_d          = cs_q;
    sh_red_d      = sh_red_q;
    sh_green_d    = sh_green_q;
    sh_blue_d     = sh_blue_q;
    red_raw_d     = red_raw_q;
    green_raw_d   = green_raw_q;
    blue_raw_d    = blue_raw_q;
    clear_raw_d   = clear_raw_q;
    frame_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SETTLE;
          cs_d    = CS_RED;
          timer_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        cnt_d = '0;
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_COUNT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_COUNT: begin
        if (edge_det && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (timer_q == WINDOW_LAST) begin
          state_d = ST_STORE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STORE: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
        case (cs_q)
          CS_RED: begin
            sh_red_d = cnt_q;
            cs_d     = CS_GREEN;
          end
          CS_GREEN: begin
            sh_green_d = cnt_q;
            cs_d       = CS_BLUE;
          end
          CS_BLUE: begin
            sh_blue_d = cnt_q;
            cs_d      = CS_CLEAR;
          end
          default: begin
            // Publish on entry to DONE so the new counts and frame_valid appear in the same cycle;
            // the clear count goes straight from the edge counter.
            cs_d          = CS_RED;
            state_d       = ST_DONE;
            red_raw_d     = sh_red_q;
            green_raw_d   = sh_green_q;
            blue_raw_d    = sh_blue_q;
            clear_raw_d   = cnt_q;
            frame_valid_d = 1'b1;
          end
        endcase
      end
      ST_DONE: begin
`ifdef COLOR_SCAN_CONT_EN
        state_d = ST_SETTLE;
        cs_d    = CS_RED;
        timer_d = '0;
        cnt_d   = '0;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition; published outputs keep the previous frame
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      cs_d          = CS_RED;
      timer_d       = '0;
      cnt_d         = '0;
      sh_red_d      = '0;
      sh_green_d    = '0;
      sh_blue_d     = '0;
      red_raw_d     = red_raw_q;
      green_raw_d   = green_raw_q;
      blue_raw_d    = blue_raw_q;
      clear_raw_d   = clear_raw_q;
      frame_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign cs          = cs_q;
  assign red_raw     = red_raw_q;
  assign green_raw   = green_raw_q;
  assign blue_raw    = blue_raw_q;
  assign clear_raw   = clear_raw_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Scoreboard bench for color_scan_ctrl: expected frames are queued at start, a monitor checks each frame_valid.
module tb_color_scan_ctrl;

  localparam int S  = 4;
  localparam int W  = 16;
  localparam int N  = S + W + 1;
  localparam int W2 = 40;
  localparam int N2 = S + W2 + 1;

  typedef struct packed {
    logic [63:0] t;
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, abort = 1'b0, sensor_out = 1'b0;
  logic [1:0]  cs, cs2;
  logic [15:0] red_raw, green_raw, blue_raw, clear_raw;
  logic [3:0]  red2, green2, blue2, clear2;
  logic        frame_valid, busy, frame_valid2, busy2;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint sens_per = 0;
  exp_t   q1[$];
  exp_t   q2[$];
  exp_t   last = '0;

  color_scan_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sensor_out(sensor_out),
    .cs(cs), .red_raw(red_raw), .green_raw(green_raw), .blue_raw(blue_raw), .clear_raw(clear_raw),
    .frame_valid(frame_valid), .busy(busy)
  );

  color_scan_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .sensor_out(sensor_out),
    .cs(cs2), .red_raw(red2), .green_raw(green2), .blue_raw(blue2), .clear_raw(clear2),
    .frame_valid(frame_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor level sampled at posedge number t
  function automatic logic pat(input longint per, input longint t);
    if (per == 0) return 1'b0;
    return (t % per) < (per / 2);
  endfunction

  // Rises first sampled at t reach the counter in the cycle after t+1, which must be a COUNT cycle
  function automatic logic [15:0] exp_cnt(input longint base, input longint w, input int cw);
    longint k = 0;
    longint lim = (longint'(1) << cw) - 1;
    for (longint t = base + S - 1; t <= base + S + w - 2; t++)
      if (pat(sens_per, t) && !pat(sens_per, t - 1)) k++;
    if (k > lim) k = lim;
    return 16'(k);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    sensor_out = pat(sens_per, cyc + 1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_scan(output longint e0);
    start = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_scan2(output longint e0);
    start2 = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
  endtask

  task automatic push_frame(input longint e0);
    exp_t e;
    e.t = 64'(e0 + 4 * N);
    e.r = exp_cnt(e0, W, 16);
    e.g = exp_cnt(e0 + N, W, 16);
    e.b = exp_cnt(e0 + 2 * N, W, 16);
    e.c = exp_cnt(e0 + 3 * N, W, 16);
    q1.push_back(e);
    last = e;
  endtask

  task automatic push_frame2(input longint e0);
    exp_t e;
    e.t = 64'(e0 + 4 * N2);
    e.r = exp_cnt(e0, W2, 4);
    e.g = exp_cnt(e0 + N2, W2, 4);
    e.b = exp_cnt(e0 + 2 * N2, W2, 4);
    e.c = exp_cnt(e0 + 3 * N2, W2, 4);
    q2.push_back(e);
  endtask

  task automatic chk_outputs(input string nm, input exp_t e);
    chk({nm, "_red"}, 64'(red_raw), 64'(e.r));
    chk({nm, "_green"}, 64'(green_raw), 64'(e.g));
    chk({nm, "_blue"}, 64'(blue_raw), 64'(e.b));
    chk({nm, "_clear"}, 64'(clear_raw), 64'(e.c));
  endtask

  // cs must hold through SETTLE/COUNT/STORE and step only at the STORE exit edge
  task automatic chk_cs_seq(input longint e0);
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int c = 0; c < 4; c++) begin
      wait_until(e0 + c * N + 1);
      chk("cs_enter", 64'(cs), 64'(seq[c]));
      wait_until(e0 + c * N + N - 1);
      chk("cs_store", 64'(cs), 64'(seq[c]));
      chk("busy_scan", 64'(busy), 64'd1);
    end
    wait_until(e0 + 4 * N);
    chk("busy_done", 64'(busy), 64'd1);
    chk("cs_done", 64'(cs), 64'd0);
    wait_until(e0 + 4 * N + 1);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  // Monitor: every frame_valid pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        if (q1.size() == 0) chk("fv_unexpected", 64'(frame_valid), 64'd0);
        else begin
          e = q1.pop_front();
          chk("fv_cycle", 64'(cyc), e.t);
          chk_outputs("frame", e);
        end
      end
      if (frame_valid2 === 1'b1) begin
        if (q2.size() == 0) chk("fv2_unexpected", 64'(frame_valid2), 64'd0);
        else begin
          e = q2.pop_front();
          chk("fv2_cycle", 64'(cyc), e.t);
          chk("sat_red", 64'(red2), 64'(e.r));
          chk("sat_green", 64'(green2), 64'(e.g));
          chk("sat_blue", 64'(blue2), 64'(e.b));
          chk("sat_clear", 64'(clear2), 64'(e.c));
        end
      end
    end
  end

  initial begin
    longint e0;
    longint e1;
    sens_per = 4;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_cs", 64'(cs), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk_outputs("rst", last);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_cs", 64'(cs), 64'd0);
    end

`ifdef COLOR_SCAN_CONT_EN
    start_scan(e0);
    for (int k = 0; k < 3; k++) push_frame(e0 + 85 * k);
    for (int i = 0; i < 3 * 85; i++) begin
      @(posedge clk);
      #1;
      chk("busy_cont", 64'(busy), 64'd1);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("cont_abort_busy", 64'(busy), 64'd0);
    chk("cont_abort_cs", 64'(cs), 64'd0);
    chk_outputs("cont_abort_hold", last);
    repeat (100) @(posedge clk);
    #1;
    chk("cont_idle_busy", 64'(busy), 64'd0);
`else
    // Scan A, period-4 sensor, then scan B accepted in the first IDLE cycle after DONE
    start_scan(e0);
    push_frame(e0);
    chk_cs_seq(e0);
    sens_per = 5;
    start_scan(e1);
    chk("b2b_e0", 64'(e1), 64'(e0 + 4 * N + 2));
    push_frame(e1);
    chk_cs_seq(e1);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);

    // Abort during blue COUNT
    sens_per = 4;
    wait_until(cyc + 4);
    start_scan(e0);
    wait_until(e0 + 2 * N + S + 4);
    abort = 1'b1;
    wait_until(e0 + 2 * N + S + 5);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cs", 64'(cs), 64'd0);
    chk_outputs("abort_hold", last);
    wait_until(cyc + 100);
    chk_outputs("abort_hold_late", last);

    // Normal scan after abort, rise every 2 cycles
    sens_per = 2;
    wait_until(cyc + 4);
    start_scan(e0);
    push_frame(e0);
    wait_until(e0 + 4 * N + 5);

    // Async reset at cycle 30 of a scan, with an ignored start at cycle 10
    sens_per = 4;
    start_scan(e0);
    wait_until(e0 + 10);
    start = 1'b1;
    wait_until(e0 + 11);
    start = 1'b0;
    wait_until(e0 + 30);
    #2;
    rst_n = 1'b0;
    #1;
    last = '0;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cs", 64'(cs), 64'd0);
    chk("arst_fv", 64'(frame_valid), 64'd0);
    chk_outputs("arst", last);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_until(cyc + 5);

    // start during busy is ignored: exactly one frame at E0+84
    start_scan(e0);
    push_frame(e0);
    wait_until(e0 + 20);
    start = 1'b1;
    wait_until(e0 + 21);
    start = 1'b0;
    wait_until(e0 + 4 * N + 30);

    // Saturation on the 4-bit instance: 20 rises per 40-cycle window
    sens_per = 2;
    wait_until(cyc + 4);
    start_scan2(e0);
    push_frame2(e0);
    wait_until(e0 + 4 * N2 + 5);
    chk("sat_busy_after", 64'(busy2), 64'd0);
`endif

    wait_until(cyc + 5);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_scan_ctrl.md
# color_scan_ctrl

Sequencer for the TCS3200-style colour sensor front end. It steps the photodiode filter select through red, green, blue and clear. For each filter it waits a settle interval, then counts sensor output edges over a fixed gate window. All four counts are published together with a one-cycle `frame_valid` strobe. It sits between the raw sensor pins and the colour classification logic, and it owns `cs` so that no other block drives the filter select.

## Interface
- `SETTLE_CYCLES`, default 1000: cycles spent with the new filter selected before counting starts (≥1).
- `WINDOW_CYCLES`, default 50000: gate length in cycles during which edges are counted (≥1).
- `CNT_W`, default 16: width of the per-channel counts.
- `clk` input, 1 bit: the single system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: requests one full four-channel scan. Sampled only in IDLE.
- `abort` input, 1 bit: cancels an in-progress scan.
- `sensor_out` input, 1 bit: sensor frequency output. Asynchronous to `clk`.
- `cs` output, 2 bits: filter select. 00 = red, 01 = green, 11 = blue, 10 = clear.
- `red_raw`, `green_raw`, `blue_raw`, `clear_raw` outputs, `CNT_W` bits each: the latest completed frame.
- `frame_valid` output, 1 bit: one-cycle strobe in the cycle the four outputs first show a new frame.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- `sensor_out` passes through a 2-flop synchronizer and then a rising-edge detector. An edge counts when the second sync flop is 1 and its delayed copy is 0.
- States are IDLE, SETTLE, COUNT, STORE and DONE.
- IDLE → SETTLE when `start`=1. On this transition, `cs` is set to 00, the channel index to 0 and the timer to 0.
- SETTLE:
  - The timer increments each cycle.
  - The edge counter is held at 0.
  - After `SETTLE_CYCLES` cycles in this state, go to COUNT with the timer cleared.
- COUNT:
  - Each detected edge increments the edge counter.
  - The counter saturates at all-ones and never wraps.
  - After `WINDOW_CYCLES` cycles in this state, go to STORE.
  - An edge detected in the last COUNT cycle is counted.
- STORE (one cycle):
  - Write the edge counter into the channel's shadow register.
  - Advance `cs` in the order 00 → 01 → 11 → 10.
  - If the channel was clear (10), go to DONE; otherwise go to SETTLE.
- DONE (one cycle):
  - Copy all four shadow registers into the outputs together.
  - Assert `frame_valid`.
  - Next state is IDLE.
- `abort`=1 in any non-IDLE state:
  - Go to IDLE on the next edge.
  - `cs` goes to 00 and the shadow registers are discarded.
  - The outputs keep the previous frame and `frame_valid` is not asserted.
  - `abort` has priority over every other transition, including STORE → DONE.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE means `abort` wins and the state stays IDLE.
- Timer width is `$clog2(max(SETTLE_CYCLES, WINDOW_CYCLES)+1)`.

## Timing
- Reset values:
  - state IDLE;
  - `cs` = 00;
  - all four count outputs 0;
  - `frame_valid` = 0, `busy` = 0;
  - shadow registers, timer, edge counter and sync flops all 0.
- Reset asserted mid-scan clears everything to these values immediately, without waiting for a clock edge.
- Per-channel time is N = `SETTLE_CYCLES` + `WINDOW_CYCLES` + 1 cycles.
- Call E0 the edge that samples `start`=1 in IDLE.
  - `busy` is high from E0.
  - `frame_valid` is high in the cycle after edge E0 + 4N and the outputs update at that same edge.
  - `busy` is high through the DONE cycle and low after the next edge.
- Latency from a `sensor_out` rise to the counter increment is 3 edges: 2 sync flops plus the edge-detect register.
- `cs` changes only at the STORE → next-state edge, at reset, or on abort. It never changes during SETTLE or COUNT.
- A new scan can be accepted in the first IDLE cycle after DONE.

## Configuration
- `COLOR_SCAN_CONT_EN`:
  - Defined: DONE goes directly to SETTLE with `cs` = 00 and a new scan begins, so the block scans continuously and `start` is ignored. Abort → IDLE, and the next `start` restarts the scan, which then runs continuously again. `busy` stays high while scanning.
  - Undefined: single-shot behaviour as described above.

## Test plan
All scenarios use `SETTLE_CYCLES`=4 and `WINDOW_CYCLES`=16, so N = 21.
- Reset then idle: hold 10 cycles with `start`=0 → `cs`=00, all counts 0, `busy`=0, `frame_valid` never high.
- Single scan with one clean edge per filter:
  - Stimulus: `sensor_out` toggles every 2 `clk` cycles (a rise every 4 cycles, i.e. period 4) during every window.
  - Required: `frame_valid` exactly once, in the cycle after E0+84.
  - Required: `cs` sequence 00, 01, 11, 10, one step per 21 cycles.
  - Required: each count equals the rises observed in its 16-cycle window, 4 ± 1 depending on sync alignment, and the bench model predicts the exact value.
- Saturation: `CNT_W`=4 with a rise every 2 cycles, giving 8 edges → the count stays at 4'hF if fed more than 15 edges, e.g. with `WINDOW_CYCLES`=40 → 4'hF and no wrap.
- Abort during blue COUNT:
  - Stimulus: the previous frame was all 7; pulse `abort`.
  - Required: IDLE next edge, `cs`=00, outputs still 7, no `frame_valid`.
  - Required: a following `start` completes a normal scan.
- Async reset at cycle 30 of a scan → outputs and state reset immediately. `start` during `busy` is ignored, shown by a single `frame_valid` at E0+84.
- With `COLOR_SCAN_CONT_EN` defined, one `start` → `frame_valid` every 85 cycles (84 + DONE) for 3 frames and `busy` never drops.
